alu_issue_arbiter: RTL and testbench

- Shares the single 16-bit compute ALU between two requesters: port 0 is the execute stage and port 1 is the debug/self-test port.
- Arbitrates round-robin and registers operands into the ALU.
- Captures the ALU result and returns it over a valid/ready response channel.
- Owns the architectural Z/N/V flag register, with per-opcode update rules.
- Sits between decode/execute control and the combinational ALU, and feeds flags to branch-condition logic.

---
 rtl/alu_issue_arbiter_pkg.sv | 28 ++
 rtl/alu_issue_arbiter_flag_reg.sv | 21 ++
 rtl/alu_issue_arbiter.sv | 137 +++++++++++++
 tb/tb_alu_issue_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared opcode map, arbiter FSM states and the per-opcode Z/N/V update mask.
// Opcodes with bit 3 set are illegal; they never touch the flags.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Bit 2 = Z, bit 1 = N, bit 0 = V.
  function automatic logic [2:0] flag_mask(input logic [3:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_flag_reg.sv
// Architectural Z/N/V flag register: per-bit write enables, synchronous reset.
// Single-cycle update, no backpressure.
module flag_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] we,
  input  logic [2:0] d,
  output logic [2:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (we[i]) q[i] <= d[i];
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of two requesters onto one ALU; accept->rsp_valid 2 cycles, issue every 3+.
// Response held until the owner's rsp_ready; optional perf counters under ALU_ARB_PERF_EN.
module alu_issue_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4,
  parameter int IMM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [IMM_W-1:0]  req0_imm,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [IMM_W-1:0]  req1_imm,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [IMM_W-1:0]  alu_imm,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [15:0]       perf_grant0,
  output logic [15:0]       perf_grant1,
  output logic [15:0]       perf_stall
`endif
);

  state_t     state;
  logic       owner;
  logic       rr_ptr;
  logic       gnt_id;
  logic [1:0] grant;
  logic       legal;
  logic [2:0] flag_we;
  logic [2:0] flags;

  // Grant is only offered from IDLE and never while reset is asserted.
  always_comb begin
    gnt_id = 1'b0;
    grant  = 2'b00;
    if (state == IDLE && !rst && req_valid != 2'b00) begin
      gnt_id = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
      grant  = gnt_id ? 2'b10 : 2'b01;
    end
  end

  assign req_ready = grant;
  assign legal     = ~alu_op[OP_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      rsp_valid <= 2'b00;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_imm   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            alu_op  <= gnt_id ? req1_op  : req0_op;
            alu_a   <= gnt_id ? req1_a   : req0_a;
            alu_b   <= gnt_id ? req1_b   : req0_b;
            alu_imm <= gnt_id ? req1_imm : req0_imm;
            owner   <= gnt_id;
            rr_ptr  <= ~gnt_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= legal ? alu_out : '0;
          rsp_err   <= ~legal;
          rsp_valid <= owner ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flag_we = (state == EXEC && legal) ? flag_mask(alu_op) : 3'b000;

  flag_reg u_flag_reg (
    .clk (clk),
    .rst (rst),
    .we  (flag_we),
    .d   ({alu_z, alu_n, alu_v}),
    .q   (flags)
  );

  assign {flag_z, flag_n, flag_v} = flags;

`ifdef ALU_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant0 <= 16'h0000;
      perf_grant1 <= 16'h0000;
      perf_stall  <= 16'h0000;
    end else begin
      if (grant[0] && perf_grant0 != 16'hFFFF) perf_grant0 <= perf_grant0 + 16'd1;
      if (grant[1] && perf_grant1 != 16'hFFFF) perf_grant1 <= perf_grant1 + 16'd1;
      // One stall count per cycle, however many requesters are left waiting.
      if ((req_valid & ~grant) != 2'b00 && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench: behavioural ALU stub on the alu_* port plus a transaction-level flag/result model.
module tb_alu_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]  req0_op, req1_op, req0_imm, req1_imm, alu_op, alu_imm;
  logic [15:0] req0_a, req0_b, req1_a, req1_b, rsp_data, alu_a, alu_b, alu_out;
  logic        rsp_err, alu_z, alu_n, alu_v, flag_z, flag_n, flag_v;

  int   vectors = 0;
  int   miscompares = 0;
  logic ez, en, ev;

  always #5 clk = ~clk;

  alu_issue_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
    .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  // Returns {z, n, v, result}.
  function automatic logic [18:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] imm);
    logic [15:0] r;
    logic        v;
    int          s;
    r = 16'h0000;
    v = 1'b0;
    case (op)
      4'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a ^ b;
      4'd3: r = {15'd0, ^a};
      4'd4: r = a << imm;
      4'd5: r = $signed(a) >>> imm;
      4'd6: r = (a >> imm) | (a << (5'd16 - {1'b0, imm}));
      4'd7: begin
        for (int k = 0; k < 2; k++) begin
          s = int'($signed(a[8*k +: 8])) + int'($signed(b[8*k +: 8]));
          if (s > 127) s = 127;
          if (s < -128) s = -128;
          r[8*k +: 8] = s[7:0];
        end
      end
      default: begin r = a | b | 16'h0100; v = 1'b1; end
    endcase
    return {(r == 16'h0000), r[15], v, r};
  endfunction

  always_comb {alu_z, alu_n, alu_v, alu_out} = alu_fn(alu_op, alu_a, alu_b, alu_imm);

  task automatic model_flags(input logic [3:0] op, input logic [18:0] res);
    if (op == 4'd0 || op == 4'd1) {ez, en, ev} = res[18:16];
    else if (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6) ez = res[18];
  endtask

  task automatic set_req(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] imm);
    if (port == 1) begin req1_op = op; req1_a = a; req1_b = b; req1_imm = imm; end
    else begin req0_op = op; req0_a = a; req0_b = b; req0_imm = imm; end
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    {ez, en, ev} = 3'b000;
  endtask

  // One full transaction on 'port'; other_req raises the other requester during RESP.
  task automatic do_txn(input int port, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] imm, input int hold, input bit other_req, input string name);
    logic [18:0] res;
    logic [15:0] exp_data;
    logic [1:0]  oh, other_oh;
    int          n;
    res      = alu_fn(op, a, b, imm);
    exp_data = op[3] ? 16'h0000 : res[15:0];
    oh       = (port == 1) ? 2'b10 : 2'b01;
    other_oh = ~oh;
    set_req(port, op, a, b, imm);
    req_valid[port] = 1'b1;
    #1;
    n = 0;
    while (req_ready[port] !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    vectors++;
    if (req_ready !== oh) begin
      miscompares++;
      $display("FAIL %s grant: req_ready=%b required %b", name, req_ready, oh);
      req_valid[port] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
    vectors++;
    if (rsp_valid !== 2'b00 || {alu_op, alu_a, alu_b, alu_imm} !== {op, a, b, imm}) begin
      miscompares++;
      $display("FAIL %s exec: rsp_valid=%b alu=%h/%h/%h/%h required 00 %h/%h/%h/%h", name, rsp_valid,
               alu_op, alu_a, alu_b, alu_imm, op, a, b, imm);
    end
    @(posedge clk); #1;
    model_flags(op, res);
    if (other_req) begin req_valid[1-port] = 1'b1; rsp_ready[1-port] = 1'b1; end
    #1;
    vectors++;
    if ({rsp_valid, rsp_data, rsp_err} !== {oh, exp_data, op[3]}) begin
      miscompares++;
      $display("FAIL %s rsp: valid=%b data=%h err=%b required %b %h %b", name, rsp_valid, rsp_data, rsp_err,
               oh, exp_data, op[3]);
    end
    vectors++;
    if ({flag_z, flag_n, flag_v} !== {ez, en, ev}) begin
      miscompares++;
      $display("FAIL %s flags: znv=%b%b%b required %b%b%b", name, flag_z, flag_n, flag_v, ez, en, ev);
    end
    for (int i = 0; i < hold; i++) begin
      rsp_ready[1-port] = 1'b1;
      @(posedge clk); #2;
      vectors++;
      if (rsp_valid !== oh || rsp_data !== exp_data || req_ready !== 2'b00) begin
        miscompares++;
        $display("FAIL %s hold%0d: valid=%b data=%h req_ready=%b required %b %h 00", name, i, rsp_valid,
                 rsp_data, req_ready, oh, exp_data);
      end
    end
    rsp_ready = 2'b00;
    rsp_ready[port] = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 2'b00) begin
      miscompares++;
      $display("FAIL %s handshake-cycle grant: req_ready=%b required 00", name, req_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    #1;
    vectors++;
    if (rsp_valid !== 2'b00 || (other_req && req_ready !== other_oh)) begin
      miscompares++;
      $display("FAIL %s release: rsp_valid=%b req_ready=%b required 00 %b", name, rsp_valid, req_ready,
               other_req ? other_oh : req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_ready = 2'b00;
    set_req(0, 4'd0, 16'h1111, 16'h2222, 4'd1);
    set_req(1, 4'd1, 16'h3333, 16'h4444, 4'd2);
    repeat (2) @(posedge clk);
    #1 req_valid = 2'b11;
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, alu_op, alu_a, alu_b, alu_imm, flag_z, flag_n, flag_v} !== '0) begin
      miscompares++;
      $display("FAIL reset: req_ready=%b rsp_valid=%b data=%h err=%b alu=%h/%h/%h/%h znv=%b%b%b required all zero",
               req_ready, rsp_valid, rsp_data, rsp_err, alu_op, alu_a, alu_b, alu_imm, flag_z, flag_n, flag_v);
    end
    do_reset();
  endtask

  task automatic test_add_flags();
    do_txn(0, 4'd0, 16'h7FFF, 16'h0001, 4'd0, 0, 1'b0, "add_ovf");
  endtask

  task automatic test_contention();
    do_reset();
    set_req(0, 4'd1, 16'h0005, 16'h0005, 4'd0);
    set_req(1, 4'd2, 16'hFFFF, 16'h0000, 4'd0);
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL contention_first: req_ready=%b required 01", req_ready);
    end
    do_txn(0, 4'd1, 16'h0005, 16'h0005, 4'd0, 0, 1'b0, "sub_zero");
    do_txn(1, 4'd2, 16'hFFFF, 16'h0000, 4'd0, 0, 1'b0, "xor_ffff");
    // Build rr_ptr=1 with both valid: requester 1 must win, then requester 0.
    do_txn(0, 4'd4, 16'h0003, 16'h0000, 4'd2, 0, 1'b0, "sll_solo");
    set_req(0, 4'd6, 16'h00F1, 16'h0000, 4'd4);
    set_req(1, 4'd5, 16'h8000, 16'h0000, 4'd15);
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b10) begin
      miscompares++;
      $display("FAIL contention_rr1: req_ready=%b required 10", req_ready);
    end
    do_txn(1, 4'd5, 16'h8000, 16'h0000, 4'd15, 0, 1'b0, "sra_rr");
    req_valid[1] = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin
      miscompares++;
      $display("FAIL contention_rr0: req_ready=%b required 01", req_ready);
    end
    req_valid[1] = 1'b0;
    do_txn(0, 4'd6, 16'h00F1, 16'h0000, 4'd4, 0, 1'b0, "ror_rr");
  endtask

  task automatic test_paddsb();
    do_txn(0, 4'd1, 16'h0003, 16'h0003, 4'd0, 0, 1'b0, "sub_setz");
    do_txn(1, 4'd7, 16'h7F80, 16'h0180, 4'd0, 0, 1'b0, "paddsb");
  endtask

  task automatic test_illegal();
    do_txn(0, 4'b1010, 16'h1234, 16'h8001, 4'd3, 0, 1'b0, "illegal");
  endtask

  task automatic test_back_to_back();
    set_req(1, 4'd5, 16'h8001, 16'h0000, 4'd3);
    do_txn(0, 4'd0, 16'h1234, 16'h1111, 4'd0, 5, 1'b1, "backpressure");
    do_txn(1, 4'd5, 16'h8001, 16'h0000, 4'd3, 0, 1'b0, "after_bp");
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int t = 0; t < 40; t++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      do_txn($urandom_range(0, 1), op, 16'($urandom), 16'($urandom), 4'($urandom), $urandom_range(0, 2),
             1'b0, "random");
    end
  endtask

  task automatic test_reset_in_exec();
    int n;
    set_req(0, 4'd0, 16'h7FFF, 16'h0001, 4'd0);
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (req_ready[0] !== 1'b1 && n < 20) begin @(posedge clk); #2; n++; end
    @(posedge clk); #1;
    req_valid = 2'b11;
    rst = 1'b1;
    @(posedge clk); #2;
    {ez, en, ev} = 3'b000;
    vectors++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, alu_op, alu_a, alu_b, alu_imm, flag_z, flag_n, flag_v} !== '0) begin
      miscompares++;
      $display("FAIL rst_in_exec: req_ready=%b rsp_valid=%b data=%h err=%b alu=%h/%h znv=%b%b%b required all zero",
               req_ready, rsp_valid, rsp_data, rsp_err, alu_op, alu_a, flag_z, flag_n, flag_v);
    end
    rst = 1'b0;
    req_valid = 2'b00;
    n = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (rsp_valid !== 2'b00) n++;
    end
    vectors++;
    if (n != 0) begin
      miscompares++;
      $display("FAIL rst_orphan_rsp: %0d cycles with rsp_valid set, required 0", n);
    end
    do_txn(1, 4'd1, 16'h8000, 16'h0001, 4'd0, 1, 1'b0, "post_rst");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    rst = 1'b1;
    {ez, en, ev} = 3'b000;
    test_reset();
    test_add_flags();
    test_contention();
    test_paddsb();
    test_illegal();
    test_back_to_back();
    test_random();
    test_reset_in_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
